// File: rtl/vga_sync_tracker.sv
// Receive-side raster tracker: recovers x/y from active-low hsync/vsync, measures line,
// hsync-pulse and frame geometry, and declares lock after consecutive consistent frames.
module vga_sync_tracker #(
   parameter int XW          = 10,
   parameter int YW          = 10,
   parameter int LOCK_FRAMES = 2,
   parameter int TOL         = 2
) (
   input  logic          clk24,
   input  logic          reset_n,
   input  logic          hsync,
   input  logic          vsync,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [XW-1:0] line_len,
   output logic [7:0]    hs_width,
   output logic [YW-1:0] frame_lines,
   output logic          line_start,
   output logic          frame_start,
   output logic          locked,
   output logic          err
);

   typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [XW-1:0] X_MAX  = {XW{1'b1}};
   localparam logic [XW-1:0] X_NEAR = X_MAX - XW'(1);
   localparam logic [YW-1:0] Y_MAX  = {YW{1'b1}};
   localparam logic [YW-1:0] Y_NEAR = Y_MAX - YW'(1);
   localparam logic [XW:0]   TOL_W  = (XW+1)'(TOL);
   localparam logic [7:0]    LOCK_N = 8'(LOCK_FRAMES);

   logic          hs_q_r, vs_q_r, vs_pending_r;
   logic [7:0]    low_cnt_r;
   state_t        state_r, state_s;
   logic [XW-1:0] ref_len_r, ref_len_s;
   logic [YW-1:0] ref_lines_r, ref_lines_s;
   logic [7:0]    cnt_r, cnt_s, cnt_inc_s;
   logic          locked_s, err_s;

   logic          hs_fall_s, hs_rise_s, vs_fall_s, frame_evt_s;
   logic [XW-1:0] x_inc_s;
   logic [YW-1:0] y_inc_s;
   logic [7:0]    low_inc_s;
   logic          x_sat_s, y_sat_s, len_ok_s, lines_ok_s;
   logic [XW:0]   diff_s, abs_s;

   // Edge detection, saturating increments and the measurement comparators.
   // The saturated increments double as the measured line length / frame lines, so a
   // stuck line reports 2^XW-1 (2^XW itself is not representable in line_len).
   always_comb begin
      hs_fall_s   = hs_q_r & ~hsync;
      hs_rise_s   = ~hs_q_r & hsync;
      vs_fall_s   = vs_q_r & ~vsync;
      frame_evt_s = hs_fall_s & (vs_pending_r | vs_fall_s);
      x_inc_s     = (x == X_MAX) ? X_MAX : x + XW'(1);
      y_inc_s     = (y == Y_MAX) ? Y_MAX : y + YW'(1);
      low_inc_s   = (low_cnt_r == 8'hFF) ? 8'hFF : low_cnt_r + 8'd1;
      x_sat_s     = ~hs_fall_s & (x == X_NEAR);
      y_sat_s     = hs_fall_s & ~frame_evt_s & (y == Y_NEAR);
      diff_s      = {1'b0, x_inc_s} - {1'b0, ref_len_r};
      abs_s       = diff_s[XW] ? (~diff_s + (XW+1)'(1)) : diff_s;
      len_ok_s    = (abs_s <= TOL_W);
      lines_ok_s  = (y_inc_s == ref_lines_r);
      cnt_inc_s   = cnt_r + 8'd1;
   end

   // Lock FSM next-state: saturation always wins and forces a fresh search.
   always_comb begin
      state_s     = state_r;
      ref_len_s   = ref_len_r;
      ref_lines_s = ref_lines_r;
      cnt_s       = cnt_r;
      locked_s    = locked;
      err_s       = 1'b0;
      if (x_sat_s | y_sat_s) begin
         state_s  = SEARCH;
         cnt_s    = 8'd0;
         locked_s = 1'b0;
         err_s    = 1'b1;
      end else begin
         case (state_r)
            SEARCH: begin
               if (frame_evt_s) begin
                  ref_len_s   = x_inc_s;
                  ref_lines_s = y_inc_s;
                  cnt_s       = 8'd1;
                  state_s     = TRACK;
               end else begin
                  state_s = SEARCH;
               end
            end
            TRACK: begin
               if (frame_evt_s) begin
                  if (lines_ok_s & len_ok_s) begin
                     cnt_s = cnt_inc_s;
                     if (cnt_inc_s >= LOCK_N) begin
                        state_s  = LOCKED;
                        locked_s = 1'b1;
                     end else begin
                        state_s = TRACK;
                     end
                  end else begin
                     ref_len_s   = x_inc_s;
                     ref_lines_s = y_inc_s;
                     cnt_s       = 8'd1;
                  end
               end else begin
                  state_s = TRACK;
               end
            end
            LOCKED: begin
               if (hs_fall_s & (~len_ok_s | (frame_evt_s & ~lines_ok_s))) begin
                  state_s  = SEARCH;
                  cnt_s    = 8'd0;
                  locked_s = 1'b0;
                  err_s    = 1'b1;
               end else begin
                  state_s = LOCKED;
               end
            end
            default: begin
               state_s  = SEARCH;
               cnt_s    = 8'd0;
               locked_s = 1'b0;
            end
         endcase
      end
   end

   // Raster counters, measurements, pulses and lock state registers.
   always_ff @(posedge clk24 or negedge reset_n) begin
      if (!reset_n) begin
         hs_q_r       <= 1'b1;
         vs_q_r       <= 1'b1;
         vs_pending_r <= 1'b0;
         low_cnt_r    <= 8'd0;
         x            <= '0;
         y            <= '0;
         line_len     <= '0;
         hs_width     <= 8'd0;
         frame_lines  <= '0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         locked       <= 1'b0;
         err          <= 1'b0;
         state_r      <= SEARCH;
         ref_len_r    <= '0;
         ref_lines_r  <= '0;
         cnt_r        <= 8'd0;
      end else begin
         hs_q_r      <= hsync;
         vs_q_r      <= vsync;
         line_start  <= hs_fall_s;
         frame_start <= frame_evt_s;
         if (hs_fall_s) begin
            x        <= '0;
            line_len <= x_inc_s;
         end else begin
            x <= x_inc_s;
         end
         if (frame_evt_s) begin
            y           <= '0;
            frame_lines <= y_inc_s;
         end else if (hs_fall_s) begin
            y <= y_inc_s;
         end
         if (frame_evt_s) begin
            vs_pending_r <= 1'b0;
         end else if (vs_fall_s) begin
            vs_pending_r <= 1'b1;
         end
         if (hs_fall_s) begin
            low_cnt_r <= 8'd0;
         end else if (!hsync) begin
            low_cnt_r <= low_inc_s;
         end
         if (hs_rise_s) begin
            hs_width <= low_inc_s;
         end
         state_r     <= state_s;
         ref_len_r   <= ref_len_s;
         ref_lines_r <= ref_lines_s;
         cnt_r       <= cnt_s;
         locked      <= locked_s;
         err         <= err_s;
      end
   end

endmodule
